// File: rtl/synthesijer_op_result_queue64.sv
// Result capture queue behind a 64-bit Synthesijer operator: issue tags track in-flight ops,
// results land in a FWFT FIFO. Define SYNTHESIJER_RESULT_QUEUE_STATS_EN to enable drop_count.
module synthesijer_op_result_queue64 #(
   parameter int LATENCY = 0,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue,
   input  logic [63:0]            op_result,
   input  logic                   op_valid,
   output logic                   issue_ok,
   output logic [63:0]            q_data,
   output logic                   q_valid,
   input  logic                   q_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   missed,
   output logic [15:0]            drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = (LATENCY > 0) ? LATENCY : 1;

   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]   count_q, count_d;
   logic [63:0]   last_q, last_d;
   logic          overflow_q, overflow_d;
   logic          missed_q, missed_d;
   logic [63:0]   mem_q [DEPTH];
   logic [5:0]    inflight, used;
   logic          issue_tag, issue_drp, cap_tag, cap_drp, push, pop;

   // Credit uses registered state only, so a same-cycle pop never grants an extra issue.
   always_comb begin
      used      = 6'(count_q) + inflight;
      issue_ok  = (used < 6'(DEPTH));
      issue_tag = issue & issue_ok;
      issue_drp = issue & ~issue_ok;
   end

   if (LATENCY == 0) begin : g_direct
      assign cap_tag  = issue_tag;
      assign cap_drp  = issue_drp;
      assign inflight = '0;
   end else begin : g_pipe
      logic [TW-1:0] tag_q, tag_d, drp_q, drp_d;

      always_comb begin
         tag_d    = tag_q << 1;
         tag_d[0] = issue_tag;
         drp_d    = drp_q << 1;
         drp_d[0] = issue_drp;
         inflight = '0;
         for (int i = 0; i < TW; i++) inflight = inflight + 6'(tag_q[i]);
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            tag_q <= '0;
            drp_q <= '0;
         end else begin
            tag_q <= tag_d;
            drp_q <= drp_d;
         end
      end

      assign cap_tag = tag_q[TW-1];
      assign cap_drp = drp_q[TW-1];
   end

   assign q_valid  = (count_q != '0);
   assign q_data   = q_valid ? mem_q[rd_q] : last_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign missed   = missed_q;

   always_comb begin
      push       = cap_tag & op_valid;
      pop        = q_valid & q_ready;
      rd_d       = rd_q + AW'(pop);
      wr_d       = wr_q + AW'(push);
      count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
      last_d     = pop ? mem_q[rd_q] : last_q;
      overflow_d = overflow_q | issue_drp;
      missed_d   = missed_q | (cap_tag & ~op_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         last_q     <= '0;
         overflow_q <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
         missed_q   <= missed_d;
      end
   end

   // Storage is never reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= op_result;
   end

`ifdef SYNTHESIJER_RESULT_QUEUE_STATS_EN
   logic        drop;
   logic [15:0] drops_q, drops_d;

   always_comb begin
      drop    = cap_drp | (cap_tag & ~op_valid);
      drops_d = (drop && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;
   end

   always_ff @(posedge clk) begin
      if (reset) drops_q <= '0;
      else       drops_q <= drops_d;
   end

   assign drop_count = drops_q;
`else
   assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_synthesijer_op_result_queue64.sv
// Bench for synthesijer_op_result_queue64: three instances (LATENCY 0/1/2, DEPTH 4) against a list-based model.
module tb_synthesijer_op_result_queue64;
   localparam int ND    = 3;
   localparam int DEPTH = 4;
`ifdef SYNTHESIJER_RESULT_QUEUE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        iss [ND];
   logic        ov  [ND];
   logic        qr  [ND];
   logic [63:0] res [ND];
   logic        iok [ND];
   logic        qv  [ND];
   logic        ovf [ND];
   logic        mis [ND];
   logic [63:0] qd  [ND];
   logic [2:0]  cnt [ND];
   logic [15:0] dc  [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      synthesijer_op_result_queue64 #(.LATENCY(g), .DEPTH(DEPTH)) u_dut (
         .clk(clk), .reset(rst), .issue(iss[g]), .op_result(res[g]), .op_valid(ov[g]),
         .issue_ok(iok[g]), .q_data(qd[g]), .q_valid(qv[g]), .q_ready(qr[g]),
         .count(cnt[g]), .overflow(ovf[g]), .missed(mis[g]), .drop_count(dc[g]));
   end

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: the queue is a plain list, in-flight ops a list of (issue cycle, granted).
   logic [63:0] mq [ND][16];
   int          mn [ND];
   logic [63:0] mlast [ND];
   int          pt [ND][16];
   bit          pok [ND][16];
   int          pn [ND];
   bit          movf [ND];
   bit          mmis [ND];
   int          mdrop [ND];
   int          cyc = 0;

   function automatic bit m_ok(int d);
      int infl = 0;
      for (int i = 0; i < pn[d]; i++) if (pok[d][i]) infl++;
      return (DEPTH - mn[d] - infl) > 0;
   endfunction

   task automatic m_check(int d);
      chk($sformatf("m%0d_issue_ok", d), iok[d], m_ok(d));
      chk($sformatf("m%0d_q_valid", d), qv[d], mn[d] > 0);
      chk($sformatf("m%0d_q_data", d), qd[d], (mn[d] > 0) ? mq[d][0] : mlast[d]);
      chk($sformatf("m%0d_count", d), cnt[d], 64'(mn[d]));
      chk($sformatf("m%0d_overflow", d), ovf[d], movf[d]);
      chk($sformatf("m%0d_missed", d), mis[d], mmis[d]);
      chk($sformatf("m%0d_drop_count", d), dc[d], STATS ? 64'(mdrop[d]) : 64'd0);
   endtask

   task automatic m_drop(int d);
      if (mdrop[d] < 65535) mdrop[d]++;
   endtask

   task automatic m_update(int d);
      bit okv, dopop, capv, capok;
      if (rst) begin
         mn[d] = 0; pn[d] = 0; mlast[d] = '0;
         movf[d] = 1'b0; mmis[d] = 1'b0; mdrop[d] = 0;
         return;
      end
      okv   = m_ok(d);
      dopop = (mn[d] > 0) && qr[d];
      capv  = 1'b0;
      capok = 1'b0;
      if (iss[d]) begin
         pt[d][pn[d]]  = cyc;
         pok[d][pn[d]] = okv;
         pn[d]++;
         if (!okv) movf[d] = 1'b1;
      end
      // instance d has latency d: the op issued d cycles ago reaches capture now
      if (pn[d] > 0 && pt[d][0] == cyc - d) begin
         capv  = 1'b1;
         capok = pok[d][0];
         for (int i = 0; i < pn[d] - 1; i++) begin
            pt[d][i]  = pt[d][i+1];
            pok[d][i] = pok[d][i+1];
         end
         pn[d]--;
      end
      if (dopop) begin
         mlast[d] = mq[d][0];
         for (int i = 0; i < mn[d] - 1; i++) mq[d][i] = mq[d][i+1];
         mn[d]--;
      end
      if (capv) begin
         if (!capok) m_drop(d);
         else if (ov[d]) begin
            mq[d][mn[d]] = res[d];
            mn[d]++;
         end else begin
            mmis[d] = 1'b1;
            m_drop(d);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < ND; d++) m_check(d);
      for (int d = 0; d < ND; d++) m_update(d);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int d = 0; d < ND; d++) begin
         iss[d] = 1'b0; ov[d] = 1'b0; qr[d] = 1'b0; res[d] = '0;
      end
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        iss;
      logic        ov;
      logic [63:0] res;
      logic        qr;
      logic        e_qv;
      logic [63:0] e_qd;
      logic [2:0]  e_cnt;
      logic        e_ok;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(logic i, logic o, logic [63:0] r, logic q,
                               logic eqv, logic [63:0] eqd, int ec, logic eok);
      vec_t v;
      v.iss = i; v.ov = o; v.res = r; v.qr = q;
      v.e_qv = eqv; v.e_qd = eqd; v.e_cnt = 3'(ec); v.e_ok = eok;
      return v;
   endfunction

   initial begin
      tbl[0] = mk(1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1, 1'b1);
      tbl[1] = mk(1'b1, 1'b1, 64'd1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 2, 1'b1);
      tbl[2] = mk(1'b1, 1'b1, 64'd2, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 3, 1'b1);
      tbl[3] = mk(1'b1, 1'b1, 64'd3, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 4, 1'b0);
      tbl[4] = mk(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'd1, 3, 1'b1);
      tbl[5] = mk(1'b1, 1'b1, 64'd4, 1'b1, 1'b1, 64'd2, 3, 1'b1);
      tbl[6] = mk(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'd3, 2, 1'b1);
      tbl[7] = mk(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 64'd4, 1, 1'b1);
      tbl[8] = mk(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd4, 0, 1'b1);
      tbl[9] = mk(1'b1, 1'b0, 64'd9, 1'b0, 1'b0, 64'd4, 0, 1'b1);

      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) m_update(d);

      // LATENCY=0 vectors: capture in the issue cycle, fill, pop, push+pop, drain, miss
      do_reset();
      chk("rst_issue_ok", iok[0], 1'b1);
      chk("rst_q_data", qd[0], 64'd0);
      for (int i = 0; i < 10; i++) begin
         iss[0] = tbl[i].iss; ov[0] = tbl[i].ov; res[0] = tbl[i].res; qr[0] = tbl[i].qr;
         tick();
         chk($sformatf("v%0d_q_valid", i), qv[0], tbl[i].e_qv);
         chk($sformatf("v%0d_q_data", i), qd[0], tbl[i].e_qd);
         chk($sformatf("v%0d_count", i), cnt[0], tbl[i].e_cnt);
         chk($sformatf("v%0d_issue_ok", i), iok[0], tbl[i].e_ok);
      end
      chk("l0_missed", mis[0], 1'b1);
      idle();

      // LATENCY=2 back-to-back with q_ready held high
      do_reset();
      for (int k = 0; k < 7; k++) begin
         iss[2] = (k < 3);
         ov[2]  = (k >= 2 && k < 5);
         res[2] = 64'(k - 1);
         qr[2]  = 1'b1;
         tick();
         chk($sformatf("l2_q_valid_c%0d", k + 1), qv[2], (k + 1 >= 3) && (k + 1 <= 5));
         if (k + 1 >= 3 && k + 1 <= 5) chk($sformatf("l2_q_data_c%0d", k + 1), qd[2], 64'(k - 1));
         chk($sformatf("l2_count_le1_c%0d", k + 1), cnt[2] <= 3'd1, 1'b1);
      end
      idle();

      // LATENCY=1 fill with q_ready low, then an overflow issue
      do_reset();
      for (int k = 0; k < 6; k++) begin
         iss[1] = (k < 5);
         ov[1]  = (k >= 1);
         res[1] = 64'(100 + k);
         tick();
         if (k == 3) chk("fill_issue_ok_low", iok[1], 1'b0);
      end
      chk("fill_count", cnt[1], 3'd4);
      chk("fill_head", qd[1], 64'd101);
      chk("fill_overflow", ovf[1], 1'b1);
      chk("fill_drop_count", dc[1], STATS ? 16'd1 : 16'd0);
      idle();
      qr[1] = 1'b1;
      tick();
      chk("pop_count", cnt[1], 3'd3);
      chk("pop_head", qd[1], 64'd102);
      qr[1] = 1'b0; iss[1] = 1'b1;
      tick();
      chk("last_credit_ok", iok[1], 1'b0);
      iss[1] = 1'b0; ov[1] = 1'b1; res[1] = 64'h55; qr[1] = 1'b1;
      tick();
      chk("push_pop_count", cnt[1], 3'd3);
      chk("push_pop_head", qd[1], 64'd103);
      ov[1] = 1'b0;
      tick();
      chk("drain_head0", qd[1], 64'd104);
      tick();
      chk("drain_head1", qd[1], 64'h55);
      tick();
      chk("drain_empty", qv[1], 1'b0);
      chk("drain_hold", qd[1], 64'h55);
      idle();

      // LATENCY=1 missed capture
      do_reset();
      iss[1] = 1'b1;
      tick();
      iss[1] = 1'b0; ov[1] = 1'b0;
      tick();
      chk("miss_flag", mis[1], 1'b1);
      chk("miss_count", cnt[1], 3'd0);
      chk("miss_drop_count", dc[1], STATS ? 16'd1 : 16'd0);

      // reset with two queued and one in flight
      do_reset();
      for (int k = 0; k < 3; k++) begin
         iss[1] = 1'b1; ov[1] = (k >= 1); res[1] = 64'(200 + k);
         tick();
      end
      chk("pre_rst_count", cnt[1], 3'd2);
      iss[1] = 1'b0; ov[1] = 1'b1; res[1] = 64'hC0C0;
      rst = 1'b1;
      tick();
      rst = 1'b0; res[1] = 64'hD0D0;
      tick();
      chk("post_rst_count", cnt[1], 3'd0);
      chk("post_rst_q_valid", qv[1], 1'b0);
      chk("post_rst_q_data", qd[1], 64'd0);
      chk("post_rst_overflow", ovf[1], 1'b0);
      chk("post_rst_missed", mis[1], 1'b0);
      chk("post_rst_issue_ok", iok[1], 1'b1);
      idle();

      // random traffic, consumer readiness swept from never to mostly
      do_reset();
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 249) == 0);
         for (int d = 0; d < ND; d++) begin
            iss[d] = 1'($urandom_range(0, 1));
            ov[d]  = ($urandom_range(0, 7) != 0);
            res[d] = {$urandom, $urandom};
            qr[d]  = ($urandom_range(0, 3) < (c / 200) % 4);
         end
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
